// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with redirect and sticky halt
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        halt_l;
  logic        h;
  logic [31:0] rpc;
  assign h = halt_l | halt_req;
  assign rpc = redirect_pc & ~32'h3;
  assign imem_req_valid = rst_n & (state == REQ);
  assign imem_req_addr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= REQ;
      pc        <= RESET_PC & ~32'h3;
      drop      <= 1'b0;
      halt_l    <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        REQ: begin
          halt_l <= h;
          if (redirect_valid) pc <= rpc;
          // an accepted request that is already stale must have its response discarded
          if (imem_req_ready) begin
            state <= WAIT;
            drop  <= redirect_valid | h;
          end else if (h) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        WAIT: begin
          halt_l <= h;
          if (redirect_valid) pc <= rpc;
          if (imem_resp_valid) begin
            if (drop | redirect_valid | h) begin
              drop   <= 1'b0;
              state  <= h ? HALT : REQ;
              halted <= h;
            end else begin
              out_inst  <= imem_resp_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else begin
            drop <= drop | redirect_valid | h;
          end
        end
        HOLD: begin
          halt_l <= h;
          // redirect wins over a simultaneous handshake: the held word is squashed
          if (redirect_valid | out_ready) begin
            pc        <= redirect_valid ? rpc : pc + 32'd4;
            fetch_cnt <= redirect_valid ? fetch_cnt : fetch_cnt + 32'd1;
            out_valid <= 1'b0;
            state     <= h ? HALT : REQ;
            halted    <= h;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch against a transaction-level PC/memory model
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic [31:0] fetch_cnt;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc, m_cnt, out_addr, f_tgt;
  bit halt_seen, hold_ok, outst, acc, hs, resp_now, use_nop, f_rd, f_halt;
  int halt_age, cd, idle, max_idle;
  int p_rdy, p_ordy, p_rd, p_halt, dmin, dmax;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return use_nop ? 32'h0000_0013 : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_cnt = 0; halt_seen = 0; hold_ok = 0; halt_age = 0;
    outst = 0; cd = 0; acc = 0; hs = 0; resp_now = 0; idle = 0; f_rd = 0; f_halt = 0;
    imem_req_ready = 0; imem_resp_valid = 0; out_ready = 0; redirect_valid = 0; halt_req = 0;
  endtask

  // one cycle: check outputs at negedge, drive inputs, advance model for the coming edge
  task automatic cycle();
    @(negedge clk);
    if (!halt_seen) check("halted_early", 32'(halted), 0);
    else if (halt_age >= 40) check("halted", 32'(halted), 1);
    check("one_outstanding", 32'(imem_req_valid & outst), 0);
    if (halt_seen) begin
      check("req_after_halt", 32'(imem_req_valid), 0);
      check("out_after_halt", 32'(out_valid & ~hold_ok), 0);
      hold_ok = hold_ok & out_valid;
    end else if (imem_req_valid) check("req_addr", imem_req_addr, m_pc);
    if (out_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_inst", out_inst, mem(out_pc));
    end
    check("fetch_cnt", fetch_cnt, m_cnt);
    imem_req_ready = $urandom_range(99) < p_rdy;
    out_ready = $urandom_range(99) < p_ordy;
    redirect_valid = f_rd || ($urandom_range(99) < p_rd);
    redirect_pc = f_rd ? f_tgt : ($urandom & 32'h0000_0FFF | 32'h8000_0000);
    halt_req = f_halt || ($urandom_range(999) < p_halt);
    f_rd = 0; f_halt = 0;
    imem_resp_valid = 0;
    imem_resp_data = $urandom;
    if (outst) begin
      if (cd == 0) begin imem_resp_valid = 1; imem_resp_data = mem(out_addr); end
      else cd--;
    end
    acc = imem_req_valid & imem_req_ready;
    hs = out_valid & out_ready;
    resp_now = imem_resp_valid;
    if (resp_now) outst = 0;
    if (acc) begin outst = 1; out_addr = imem_req_addr; cd = int'($urandom_range(dmax, dmin)); end
    if (redirect_valid) m_pc = redirect_pc & ~32'h3;
    else if (hs) begin m_pc = m_pc + 4; m_cnt = m_cnt + 1; end
    if (halt_seen) halt_age++;
    else if (halt_req) begin halt_seen = 1; hold_ok = out_valid; halt_age = 0; end
    if (acc || hs || halt_seen) idle = 0; else idle++;
    if (idle > max_idle) max_idle = idle;
  endtask

  initial begin
    int seen_out;
    logic [31:0] cnt_b;
    use_nop = 1; p_rdy = 0; p_ordy = 0; p_rd = 0; p_halt = 0; dmin = 0; dmax = 0; max_idle = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fetch_cnt", fetch_cnt, 0);
    rst_n = 1;

    p_rdy = 100; p_ordy = 100;
    repeat (10) cycle();
    check("best_cnt", fetch_cnt, 3);

    use_nop = 0; p_ordy = 0; dmax = 1;
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    check("hold_reached", 32'(out_valid), 1);
    repeat (5) begin
      cycle();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_noreq", 32'(imem_req_valid), 0);
    end

    p_ordy = 100; dmin = 2; dmax = 2;
    for (int i = 0; i < 20 && !acc; i++) cycle();
    check("wait_acc_seen", 32'(acc), 1);
    f_rd = 1; f_tgt = 32'h8000_1002;
    cycle();
    seen_out = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      seen_out |= int'(out_valid);
      if (imem_req_valid) break;
    end
    check("wait_redir_noout", 32'(seen_out), 0);
    check("wait_redir_req", 32'(imem_req_valid), 1);
    check("wait_redir_addr", imem_req_addr, 32'h8000_1000);

    p_ordy = 0; dmin = 0; dmax = 1;
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    check("hold2_reached", 32'(out_valid), 1);
    cnt_b = m_cnt; f_rd = 1; f_tgt = 32'h8000_2000; p_ordy = 100;
    cycle();
    cycle();
    check("hold_redir_cnt", fetch_cnt, cnt_b);
    check("hold_redir_req", 32'(imem_req_valid), 1);
    check("hold_redir_addr", imem_req_addr, 32'h8000_2000);

    p_rdy = 60; p_ordy = 60; p_rd = 8; dmin = 0; dmax = 3; max_idle = 0;
    repeat (3000) cycle();
    check("progress", 32'(max_idle < 40), 1);

    p_rd = 0; p_rdy = 100; p_ordy = 100; dmin = 2; dmax = 2;
    for (int i = 0; i < 20 && !acc; i++) cycle();
    check("halt_acc_seen", 32'(acc), 1);
    f_halt = 1;
    cycle();
    for (int i = 0; i < 10 && !resp_now; i++) cycle();
    check("halt_resp_seen", 32'(resp_now), 1);
    cycle();
    check("halt_after_resp", 32'(halted), 1);
    check("halt_no_out", 32'(out_valid), 0);
    p_rd = 30; p_rdy = 50;
    repeat (20) cycle();
    check("halt_sticky", 32'(halted), 1);

    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    p_rd = 0; p_rdy = 100; p_ordy = 0; dmin = 0; dmax = 1;
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    check("rst_hold_reached", 32'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_outv", 32'(out_valid), 0);
    check("async_rst_req", 32'(imem_req_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    p_ordy = 100;
    cycle();
    check("rst_first_addr", imem_req_addr, 32'h8000_0000);
    check("rst_cnt", fetch_cnt, 0);

    p_rdy = 60; p_ordy = 60; p_rd = 5; p_halt = 3; dmax = 3;
    repeat (1500) cycle();
    f_halt = 1;
    repeat (50) cycle();
    check("final_halted", 32'(halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
